// File: rtl/param_search_pipeline_if.sv
// Search-engine bus: array write port, search request, and result outputs.
// match_count exists only when SEARCH_MATCH_COUNT_EN is defined.
interface param_search_pipeline_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int AW = $clog2(DEPTH);

    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              start;
    logic [DATA_W-1:0] key;
    logic              mode;
    logic              busy;
    logic              done;
    logic              found;
    logic [AW-1:0]     index;
`ifdef SEARCH_MATCH_COUNT_EN
    logic [AW:0]       match_count;

    modport master (
        output wr_en, wr_addr, wr_data, start, key, mode,
        input  busy, done, found, index, match_count
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, start, key, mode,
        output busy, done, found, index, match_count
    );
`else
    modport master (
        output wr_en, wr_addr, wr_data, start, key, mode,
        input  busy, done, found, index
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, start, key, mode,
        output busy, done, found, index
    );
`endif
endinterface

// File: rtl/param_search_pipeline.sv
// Multi-lane pipelined key search over an internal array (compare stage, reduce stage).
// Optional feature: define SEARCH_MATCH_COUNT_EN to add the match_count popcount output.
module param_search_pipeline #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int LANES  = 4
) (
    input logic                    clk,
    input logic                    reset,
    param_search_pipeline_if.slave bus
);
    localparam int AW     = $clog2(DEPTH);
    localparam int GROUPS = DEPTH / LANES;
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     grp_q, grp_d;
    logic              drain_q, drain_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] key_q, key_d;
    logic              mode_q, mode_d;
    logic              found_q, found_d;
    logic [AW-1:0]     index_q, index_d;
    logic              s1_valid_q, s1_valid_d;
    logic [LANES-1:0]  s1_hits_q, s1_hits_d;
    logic [AW-1:0]     s1_base_q, s1_base_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_ok_c;
    logic [AW-1:0]     base_c;
    logic [AW-1:0]     lane_addr [LANES];
    logic [LANES-1:0]  hit_c;
    logic [AW-1:0]     lo_c, hi_c;
    logic              any_c;

`ifdef SEARCH_MATCH_COUNT_EN
    localparam logic [AW:0] ONE_CNT = 1;
    logic [AW:0] count_q, count_d;
    logic [AW:0] pop_c;
`endif

    assign wr_ok_c = (state_q == S_IDLE) && bus.wr_en;
    assign base_c  = AW'(int'(grp_q) * LANES);

    // Stage 0: one lane group of comparators against the latched key.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign lane_addr[gi] = base_c + AW'(gi);
        assign hit_c[gi]     = (mem_q[lane_addr[gi]] == key_q);
    end

    // Reduce the registered hit vector: lowest and highest hit, plus popcount.
    always_comb begin
        lo_c  = '0;
        hi_c  = '0;
        any_c = 1'b0;
`ifdef SEARCH_MATCH_COUNT_EN
        pop_c = '0;
`endif
        for (int l = LANES - 1; l >= 0; l--) begin
            if (s1_hits_q[l]) begin
                lo_c  = s1_base_q + AW'(l);
                any_c = 1'b1;
`ifdef SEARCH_MATCH_COUNT_EN
                pop_c = pop_c + ONE_CNT;
`endif
            end
        end
        for (int l = 0; l < LANES; l++) begin
            if (s1_hits_q[l]) hi_c = s1_base_q + AW'(l);
        end
    end

    always_comb begin
        state_d    = state_q;
        grp_d      = grp_q;
        drain_d    = drain_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        key_d      = key_q;
        mode_d     = mode_q;
        found_d    = found_q;
        index_d    = index_q;
        s1_valid_d = 1'b0;
        s1_hits_d  = s1_hits_q;
        s1_base_d  = s1_base_q;
`ifdef SEARCH_MATCH_COUNT_EN
        count_d    = count_q;
`endif

        // Stage 2 runs ahead of the FSM so an accepted start can override the clear below.
        if (s1_valid_q && any_c) begin
            found_d = 1'b1;
            if (mode_q) index_d = hi_c;
            else if (!found_q) index_d = lo_c;
`ifdef SEARCH_MATCH_COUNT_EN
            count_d = count_q + pop_c;
`endif
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    key_d   = bus.key;
                    mode_d  = bus.mode;
                    found_d = 1'b0;
                    index_d = '0;
`ifdef SEARCH_MATCH_COUNT_EN
                    count_d = '0;
`endif
                    grp_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                s1_valid_d = 1'b1;
                s1_hits_d  = hit_c;
                s1_base_d  = base_c;
                grp_d      = grp_q + 1'b1;
                if (grp_q == GW'(GROUPS - 1)) begin
                    drain_d = 1'b0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            grp_q      <= '0;
            drain_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            key_q      <= '0;
            mode_q     <= 1'b0;
            found_q    <= 1'b0;
            index_q    <= '0;
            s1_valid_q <= 1'b0;
            s1_hits_q  <= '0;
            s1_base_q  <= '0;
`ifdef SEARCH_MATCH_COUNT_EN
            count_q    <= '0;
`endif
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            grp_q      <= grp_d;
            drain_q    <= drain_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            key_q      <= key_d;
            mode_q     <= mode_d;
            found_q    <= found_d;
            index_q    <= index_d;
            s1_valid_q <= s1_valid_d;
            s1_hits_q  <= s1_hits_d;
            s1_base_q  <= s1_base_d;
`ifdef SEARCH_MATCH_COUNT_EN
            count_q    <= count_d;
`endif
            if (wr_ok_c) mem_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.found = found_q;
    assign bus.index = index_q;
`ifdef SEARCH_MATCH_COUNT_EN
    assign bus.match_count = count_q;
`endif

endmodule

// File: tb/tb_param_search_pipeline.sv
// Table-driven, scoreboard-checked bench for param_search_pipeline (DEPTH=16, DATA_W=8).
module tb_param_search_pipeline;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int LANES  = 4;
    localparam int AW     = $clog2(DEPTH);
    localparam int LAT    = DEPTH / LANES + 2;

    typedef struct packed {
        logic          found;
        logic [AW-1:0] idx;
        logic [AW:0]   cnt;
    } exp_t;

    typedef struct {
        int          fill;
        logic [7:0]  key;
        logic        mode;
        exp_t        exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];
    vec_t vecs[11];

    param_search_pipeline_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    param_search_pipeline #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LANES(LANES)) dut (
        .clk   (clk),
        .reset (reset_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic [7:0] fill_val(input int fill, input int i);
        case (fill)
            0:       return 8'(3 * i);
            1:       return (i == 2 || i == 7 || i == 13) ? 8'h55 : 8'h00;
            default: return 8'h11;
        endcase
    endfunction

    task automatic load_fill(input int fill);
        for (int i = 0; i < DEPTH; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = AW'(i);
            bus.wr_data = fill_val(fill, i);
            @(posedge clk); #1;
        end
        bus.wr_en = 1'b0;
    endtask

    // Drives one search and checks timing and results against the scoreboard entry.
    task automatic run_search(input logic [7:0] k, input logic m, input exp_t e,
                              input bit intf, input bit wsim,
                              input logic [AW-1:0] wa, input logic [7:0] wd);
        int   cyc;
        exp_t got;
        sb_q.push_back(e);
        bus.start = 1'b1;
        bus.key   = k;
        bus.mode  = m;
        if (wsim) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = wa;
            bus.wr_data = wd;
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        bus.key   = ~k;
        bus.mode  = ~m;
        check("busy_at_t0", 32'(bus.busy), 32'd1);
        cyc = 0;
        while (!bus.done && cyc < 200) begin
            if (intf && cyc == 1) begin
                bus.start   = 1'b1;
                bus.key     = 8'h00;
                bus.wr_en   = 1'b1;
                bus.wr_addr = AW'(3);
                bus.wr_data = 8'hFF;
            end else begin
                bus.start = 1'b0;
                bus.wr_en = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        check("done_seen", 32'(bus.done), 32'd1);
        check("done_latency", 32'(cyc), 32'(LAT));
        check("busy_at_done", 32'(bus.busy), 32'd0);
        got = sb_q.pop_front();
        check("found", 32'(bus.found), 32'(got.found));
        check("index", 32'(bus.index), 32'(got.idx));
`ifdef SEARCH_MATCH_COUNT_EN
        check("match_count", 32'(bus.match_count), 32'(got.cnt));
`endif
        $display("search key=%02h mode=%0d -> found=%0d index=%0d latency=%0d",
                 k, m, bus.found, bus.index, cyc);
        @(posedge clk); #1;
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("found_hold", 32'(bus.found), 32'(got.found));
        check("index_hold", 32'(bus.index), 32'(got.idx));
    endtask

    initial begin
        int cur_fill;
        int done_cnt;
        vecs[0]  = '{0, 8'd9,   1'b0, '{1'b1, 4'd3,  5'd1}};
        vecs[1]  = '{0, 8'd9,   1'b1, '{1'b1, 4'd3,  5'd1}};
        vecs[2]  = '{0, 8'd45,  1'b0, '{1'b1, 4'd15, 5'd1}};
        vecs[3]  = '{0, 8'd0,   1'b1, '{1'b1, 4'd0,  5'd1}};
        vecs[4]  = '{0, 8'hAA,  1'b0, '{1'b0, 4'd0,  5'd0}};
        vecs[5]  = '{1, 8'h55,  1'b0, '{1'b1, 4'd2,  5'd3}};
        vecs[6]  = '{1, 8'h55,  1'b1, '{1'b1, 4'd13, 5'd3}};
        vecs[7]  = '{1, 8'h00,  1'b0, '{1'b1, 4'd0,  5'd13}};
        vecs[8]  = '{1, 8'h00,  1'b1, '{1'b1, 4'd15, 5'd13}};
        vecs[9]  = '{2, 8'h11,  1'b1, '{1'b1, 4'd15, 5'd16}};
        vecs[10] = '{1, 8'hAA,  1'b1, '{1'b0, 4'd0,  5'd0}};

        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.start = 1'b0; bus.key = '0; bus.mode = 1'b0;

        #2;
        check("rst_busy",  32'(bus.busy),  32'd0);
        check("rst_done",  32'(bus.done),  32'd0);
        check("rst_found", 32'(bus.found), 32'd0);
        check("rst_index", 32'(bus.index), 32'd0);
`ifdef SEARCH_MATCH_COUNT_EN
        check("rst_count", 32'(bus.match_count), 32'd0);
`endif
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;

        cur_fill = -1;
        for (int v = 0; v < 11; v++) begin
            if (vecs[v].fill != cur_fill) begin
                load_fill(vecs[v].fill);
                cur_fill = vecs[v].fill;
            end
            run_search(vecs[v].key, vecs[v].mode, vecs[v].exp, 1'b0, 1'b0, '0, '0);
        end

        // start and write during SCAN are both dropped
        load_fill(0);
        run_search(8'd9, 1'b0, '{1'b1, 4'd3, 5'd1}, 1'b1, 1'b0, '0, '0);
        run_search(8'hFF, 1'b0, '{1'b0, 4'd0, 5'd0}, 1'b0, 1'b0, '0, '0);
        run_search(8'd9, 1'b1, '{1'b1, 4'd3, 5'd1}, 1'b0, 1'b0, '0, '0);

        // write and start on the same edge: search sees the new value
        run_search(8'h77, 1'b0, '{1'b1, 4'd5, 5'd1}, 1'b0, 1'b1, AW'(5), 8'h77);

        // reset mid-SCAN aborts with no done, and clears the array
        load_fill(0);
        run_search(8'd9, 1'b0, '{1'b1, 4'd3, 5'd1}, 1'b0, 1'b0, '0, '0);
        bus.start = 1'b1; bus.key = 8'd45; bus.mode = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_reset_busy", 32'(bus.busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("async_rst_busy",  32'(bus.busy),  32'd0);
        check("async_rst_found", 32'(bus.found), 32'd0);
        check("async_rst_index", 32'(bus.index), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (bus.done) done_cnt++;
        end
        check("no_done_after_abort", 32'(done_cnt), 32'd0);
        $display("reset abort: done pulses after abort=%0d", done_cnt);

        // first edge after release accepts start
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        run_search(8'h00, 1'b0, '{1'b1, 4'd0, 5'd16}, 1'b0, 1'b0, '0, '0);
        run_search(8'h00, 1'b1, '{1'b1, 4'd15, 5'd16}, 1'b0, 1'b0, '0, '0);

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/param_search_pipeline.md
PARAM_SEARCH_PIPELINE -- requirements
Module: param_search_pipeline

Interface
REQ-001 SHALL have parameter DATA_W, default 8: element and key width in bits.
REQ-002 SHALL have parameter DEPTH, default 16: number of array entries; a power of two, at least 2.
REQ-003 SHALL have parameter LANES, default 4: entries compared per cycle; a power of two that divides DEPTH.
REQ-004 SHALL have derived localparam AW = clog2(DEPTH); it is not overridable.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 wr_en  in  1  array write strobe.
REQ-008 wr_addr  in  AW  array write address.
REQ-009 wr_data  in  DATA_W  array write data.
REQ-010 start  in  1  search request.
REQ-011 key  in  DATA_W  search key, sampled with start.
REQ-012 mode  in  1  0 = first match (lowest index), 1 = last match (highest index); sampled with start.
REQ-013 busy  out  1  high while a search is in progress.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 found  out  1  set if the last search had at least one match.
REQ-016 index  out  AW  index of the selected match.
REQ-017 match_count  out  AW+1  number of matching entries; present only per REQ-033.

Function
REQ-018 SHALL hold DEPTH x DATA_W internal storage, written when wr_en=1 and state is IDLE; writes SHALL be ignored in all other states.
REQ-019 SHALL implement FSM IDLE -> SCAN -> DRAIN -> DONE -> IDLE.
REQ-020 IDLE: start=1 at edge T0 SHALL latch key and mode, clear the result registers, and enter SCAN; busy SHALL be 1 from T0.
REQ-021 SCAN: SHALL compare entries base..base+LANES-1 each cycle, with base advancing by LANES from 0; SHALL hold for DEPTH/LANES cycles; no early termination.
REQ-022 Pipeline: compare results SHALL be registered (stage 1), then reduced into found/index/count (stage 2); DRAIN SHALL last 2 cycles to flush both stages.
REQ-023 DONE: SHALL last 1 cycle, with done=1 and busy=0, at edge T0+DEPTH/LANES+2; the FSM SHALL then return to IDLE.
REQ-024 Within a lane group, mode 0 SHALL select the lowest matching index and mode 1 the highest; across groups, mode 0 SHALL keep the first hit and mode 1 SHALL overwrite with each later hit.
REQ-025 No match: found=0, index=0.
REQ-026 found, index and match_count SHALL hold from DONE until the next accepted start.
REQ-027 start while not IDLE SHALL be ignored, with no queuing.
REQ-028 wr_en and start at the same edge in IDLE: the write SHALL complete, and the search SHALL see the new value.
REQ-029 Key and mode changes after acceptance SHALL NOT affect the running search.

Reset
REQ-030 reset=0 SHALL immediately, without a clock, force: state IDLE; busy=0, done=0, found=0, index=0, match_count=0; all array entries 0; pipeline valid bits 0.
REQ-031 Reset asserted mid-SCAN or mid-DRAIN SHALL abort the search; no done pulse SHALL follow.
REQ-032 After reset deasserts, the first rising edge SHALL accept start normally.

Configuration
REQ-033 Macro SEARCH_MATCH_COUNT_EN:
- Defined: match_count port and popcount-accumulate logic are present; match_count = total matches over all DEPTH entries, independent of mode; valid at DONE.
- Undefined: port and logic are absent; all other behaviour is identical.

Verification (DEPTH=16, LANES=4, DATA_W=8, macro defined)
REQ-034 Load mem[i]=3*i, start key=9 mode=0 -> done at T0+6, found=1, index=3, match_count=1, busy low at the same edge.
REQ-035 mem[2]=mem[7]=mem[13]=0x55, others 0 -> key=0x55 mode=0 gives index=2; mode=1 gives index=13; match_count=3 for both.
REQ-036 key=0xAA not present -> found=0, index=0, match_count=0, done still at T0+6.
REQ-037 During SCAN, start with key=0 and wr_en addr=3 data=0xFF -> both ignored; original result returned; mem[3] unchanged on a subsequent search.
REQ-038 reset=0 at T0+3 -> busy, found and index 0 immediately; no done pulse; search for key=0 after release gives found=1, index=0 (array cleared).
REQ-039 Rebuild with LANES=1 -> scenario REQ-034 gives done at T0+18 with identical results.
